// File: rtl/pixel_capture_if.sv
// Camera byte stream in, assembled pixel stream out.
// The capture block uses the master view; whoever drives the camera pins and consumes pixels uses the slave view.
interface pixel_capture_if #(
   parameter int BYTES_PER_PIX = 2
);
   logic                         vsync;
   logic                         href;
   logic [7:0]                   din;
   logic [8*BYTES_PER_PIX-1:0]   dout;
   logic                         dout_vld;
   logic                         dout_sop;
   logic                         dout_eol;
   logic                         dout_eop;

   modport master (
      input  vsync, href, din,
      output dout, dout_vld, dout_sop, dout_eol, dout_eop
   );

   modport slave (
      output vsync, href, din,
      input  dout, dout_vld, dout_sop, dout_eol, dout_eop
   );
endinterface

// File: rtl/pixel_capture.sv
// DVP-style camera capture: frames are framed by vsync and lines by href.
// Bytes are packed into pixels, and the block flags sop/eol/eop, aborts malformed frames, and can drop frames between captures.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | capture disabled, counters held clear
// WAIT_VS | waiting for vsync falling edge (start of frame)
// ACTIVE  | accepting href bytes of the current frame
// SKIP    | discarding a whole frame, leaves on vsync rising edge
// DRAIN   | line complete, ignoring bytes until href drops
module pixel_capture #(
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int BYTES_PER_PIX = 2,
   parameter int SWAP          = 0,
   parameter int SKIP_FRAMES   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   pixel_capture_if.master       cam,
   output logic                  frame_err,
   output logic [15:0]           frame_cnt
);

   typedef enum logic [2:0] {IDLE, WAIT_VS, ACTIVE, SKIP, DRAIN} state_t;

   localparam int BYTES_LINE = H_ACTIVE * BYTES_PER_PIX;
   localparam int BW = $clog2(BYTES_LINE);
   localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

   localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES_LINE - 1);
   localparam logic [BW-1:0] BYTE_SOP  = BW'(BYTES_PER_PIX - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);
   localparam logic [SW-1:0] SKIP_LOAD = SW'(SKIP_FRAMES);

   state_t                       state;
   logic                         vs_s1;
   logic                         vs_s2;
   logic [BW-1:0]                byte_cnt;
   logic [LW-1:0]                line_cnt;
   logic [SW-1:0]                skip_cnt;
   logic [7:0]                   byte0;
   logic [8*BYTES_PER_PIX-1:0]   pix_word;
   logic                         pix_done;
   logic                         vs_fall;
   logic                         vs_rise;
   logic                         last_byte;
   logic                         last_line;

   assign vs_fall   = vs_s2 & ~vs_s1;
   assign vs_rise   = ~vs_s2 & vs_s1;
   assign last_byte = (byte_cnt == BYTE_LAST);
   assign last_line = (line_cnt == LINE_LAST);

   // byte0 holds the even byte of a two-byte pixel until its partner arrives
   generate
      if (BYTES_PER_PIX == 2) begin : g_two_byte
         assign pix_word = (SWAP != 0) ? {cam.din, byte0} : {byte0, cam.din};
         assign pix_done = byte_cnt[0];
      end else begin : g_one_byte
         assign pix_word = cam.din;
         assign pix_done = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         vs_s1        <= 1'b0;
         vs_s2        <= 1'b0;
         byte_cnt     <= '0;
         line_cnt     <= '0;
         skip_cnt     <= '0;
         byte0        <= '0;
         cam.dout     <= '0;
         cam.dout_vld <= 1'b0;
         cam.dout_sop <= 1'b0;
         cam.dout_eol <= 1'b0;
         cam.dout_eop <= 1'b0;
         frame_err    <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         vs_s1        <= cam.vsync;
         vs_s2        <= vs_s1;
         cam.dout_vld <= 1'b0;
         cam.dout_sop <= 1'b0;
         cam.dout_eol <= 1'b0;
         cam.dout_eop <= 1'b0;
         frame_err    <= 1'b0;

         if (!enable) begin
            state    <= IDLE;
            byte_cnt <= '0;
            line_cnt <= '0;
            skip_cnt <= '0;
         end else begin
            case (state)
               IDLE: state <= WAIT_VS;

               WAIT_VS: begin
                  byte_cnt <= '0;
                  line_cnt <= '0;
                  if (vs_fall) state <= (skip_cnt == '0) ? ACTIVE : SKIP;
               end

               SKIP: begin
                  if (vs_rise) begin
                     skip_cnt <= skip_cnt - SW'(1);
                     state    <= WAIT_VS;
                  end
               end

               ACTIVE: begin
                  // short frame and short line collapse into one abort, so one err pulse
                  if (vs_rise || (!cam.href && byte_cnt != '0)) begin
                     frame_err <= 1'b1;
                     byte_cnt  <= '0;
                     line_cnt  <= '0;
                     skip_cnt  <= '0;
                     state     <= WAIT_VS;
                  end else if (cam.href) begin
                     byte0 <= cam.din;
                     if (pix_done) begin
                        cam.dout     <= pix_word;
                        cam.dout_vld <= 1'b1;
                        cam.dout_sop <= (byte_cnt == BYTE_SOP) && (line_cnt == '0);
                        cam.dout_eol <= last_byte;
                        cam.dout_eop <= last_byte && last_line;
                        if (last_byte && last_line) frame_cnt <= frame_cnt + 16'd1;
                     end
                     if (last_byte) begin
                        byte_cnt <= '0;
                        if (last_line) begin
                           line_cnt <= '0;
                           skip_cnt <= SKIP_LOAD;
                           state    <= WAIT_VS;
                        end else begin
                           line_cnt <= line_cnt + LW'(1);
                           state    <= DRAIN;
                        end
                     end else begin
                        byte_cnt <= byte_cnt + BW'(1);
                     end
                  end
               end

               DRAIN: begin
                  if (vs_rise) begin
                     frame_err <= 1'b1;
                     byte_cnt  <= '0;
                     line_cnt  <= '0;
                     skip_cnt  <= '0;
                     state     <= WAIT_VS;
                  end else if (!cam.href) begin
                     state <= ACTIVE;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
